// File: rtl/adder_inverse_pkg.sv
// Shared constants and the per-stage payload for the chunked subtractor pipeline.
package adder_inverse_pkg;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  localparam int ADDER_WIDTH      = 113;
  localparam int CHUNK_WIDTH      = 32;
  // Operands travel (W+1) bits wide: sum as-is, a zero-extended by one bit.
  localparam int OP_WIDTH         = ADDER_WIDTH + 1;
  localparam int NUM_CHUNKS       = ceil_div(OP_WIDTH, CHUNK_WIDTH);
  localparam int LAST_CHUNK_WIDTH = OP_WIDTH - (NUM_CHUNKS - 1) * CHUNK_WIDTH;

  typedef struct packed {
    logic                valid;
    logic                borrow;
    logic [OP_WIDTH-1:0] sum_rem;
    logic [OP_WIDTH-1:0] a_rem;
    logic [OP_WIDTH-1:0] res;
  } stage_t;

endpackage

// File: rtl/sub_chunk_stage.sv
// One pipeline slice: subtracts its chunk of the operands with the incoming
// borrow, retires that operand chunk and registers the item under advance.
module sub_chunk_stage
  import adder_inverse_pkg::*;
#(
  parameter int WIDTH = CHUNK_WIDTH,
  parameter int LSB   = 0
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   advance,
  input  stage_t d,
  output stage_t q
);

  logic [WIDTH:0] chunk_diff;
  stage_t         nxt;

  always_comb begin
    // NOTE: the whole struct gets a default before any field is patched, so no latch is inferred.
    nxt        = d;
    // The extra top bit of chunk_diff goes to 1 exactly when the slice goes negative.
    chunk_diff = {1'b0, d.sum_rem[LSB +: WIDTH]}
               - {1'b0, d.a_rem[LSB +: WIDTH]}
               - {{WIDTH{1'b0}}, d.borrow};
    nxt.sum_rem[LSB +: WIDTH] = '0;
    nxt.a_rem[LSB +: WIDTH]   = '0;
    nxt.res[LSB +: WIDTH]     = chunk_diff[WIDTH-1:0];
    nxt.borrow                = chunk_diff[WIDTH];
  end

  always_ff @(posedge clk) begin
    // NOTE: data fields are reset along with valid so a flushed pipe holds no stale operands.
    if (reset) begin
      q <= '0;
    end else if (advance) begin
      // NOTE: non-blocking assignment keeps every stage sampling the pre-edge value of its neighbour.
      q <= nxt;
    end
  end

endmodule

// File: rtl/adder_inverse_pipe.sv
// Pipelined inverse adder: b = sum - a, one borrow-chain chunk per stage.
// Optional input register stage enabled by defining ADDER_INVERSE_INREG_EN.
module adder_inverse_pipe
  import adder_inverse_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDER_WIDTH:0]   sum,
  input  logic [ADDER_WIDTH-1:0] a,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDER_WIDTH-1:0] b,
  output logic                   underflow,
  output logic                   overflow
);

  logic   advance;
  stage_t head;
  stage_t pipe [NUM_CHUNKS];

  // The whole pipe moves as one; bubbles are not squeezed out.
  assign advance  = out_ready | ~pipe[NUM_CHUNKS-1].valid;
  assign in_ready = advance;

`ifdef ADDER_INVERSE_INREG_EN
  logic                   in_valid_q;
  logic [ADDER_WIDTH:0]   sum_q;
  logic [ADDER_WIDTH-1:0] a_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_valid_q <= 1'b0;
      sum_q      <= '0;
      a_q        <= '0;
    end else if (advance) begin
      in_valid_q <= in_valid;
      sum_q      <= sum;
      a_q        <= a;
    end
  end

  always_comb begin
    head         = '0;
    head.valid   = in_valid_q;
    head.sum_rem = sum_q;
    head.a_rem   = {1'b0, a_q};
  end
`else
  always_comb begin
    head         = '0;
    head.valid   = in_valid;
    head.sum_rem = sum;
    head.a_rem   = {1'b0, a};
  end
`endif

  for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_stage
    localparam int WIDTH = (k == NUM_CHUNKS - 1) ? LAST_CHUNK_WIDTH : CHUNK_WIDTH;
    stage_t stage_in;

    if (k == 0) begin : g_head
      assign stage_in = head;
    end else begin : g_chain
      assign stage_in = pipe[k-1];
    end

    sub_chunk_stage #(
      .WIDTH(WIDTH),
      .LSB  (k * CHUNK_WIDTH)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .advance(advance),
      .d      (stage_in),
      .q      (pipe[k])
    );
  end

  // Result bit W set without a final borrow means the difference needs W+1 bits.
  always_comb begin
    out_valid = pipe[NUM_CHUNKS-1].valid;
    b         = '0;
    underflow = 1'b0;
    overflow  = 1'b0;
    if (out_valid) begin
      b         = pipe[NUM_CHUNKS-1].res[ADDER_WIDTH-1:0];
      underflow = pipe[NUM_CHUNKS-1].borrow;
      overflow  = pipe[NUM_CHUNKS-1].res[ADDER_WIDTH] & ~pipe[NUM_CHUNKS-1].borrow;
    end
  end

endmodule

// File: tb/tb_adder_inverse_pipe.sv
// Directed bench for adder_inverse_pipe: arithmetic corners, stall/ordering, mid-flight reset.
module tb_adder_inverse_pipe;

`ifdef ADDER_INVERSE_INREG_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [113:0] sum;
  logic [112:0] a;
  logic         out_valid;
  logic         out_ready;
  logic [112:0] b;
  logic         underflow;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  adder_inverse_pipe dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum      (sum),
    .a        (a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .b        (b),
    .underflow(underflow),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sum = '0; a = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || b !== '0 || underflow !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b b=%h uf=%b of=%b want all 0", out_valid, b, underflow, overflow);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
  endtask

  // Single item through an idle pipe: latency, value, flags, then out_valid drops.
  task automatic test_vector(input logic [113:0] s, input logic [112:0] av,
                             input logic [112:0] eb, input logic euf, input logic eof,
                             input string name);
    int lat;
    @(posedge clk); #1;
    sum = s; a = av; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready got %b want 1", name, in_ready);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, lat, LAT);
    end
    checks++;
    if (b !== eb) begin
      errors++;
      $display("FAIL %s b got %h want %h", name, b, eb);
    end
    checks++;
    if (underflow !== euf || overflow !== eof) begin
      errors++;
      $display("FAIL %s flags got uf=%b of=%b want uf=%b of=%b", name, underflow, overflow, euf, eof);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s drop got out_valid=%b want 0", name, out_valid);
    end
  endtask

  task automatic test_arith();
    test_vector(114'd5, 113'd3, 113'd2, 1'b0, 1'b0, "small");
    test_vector(114'd0, 113'd1, {113{1'b1}}, 1'b1, 1'b0, "underflow");
    test_vector(114'd1 << 113, 113'd0, 113'd0, 1'b0, 1'b1, "overflow");
    test_vector(114'd1 << 32, 113'd1, 113'hFFFF_FFFF, 1'b0, 1'b0, "borrow_chunk1");
    test_vector(114'd1 << 96, 113'd1, (113'd1 << 96) - 113'd1, 1'b0, 1'b0, "borrow_chunk3");
    test_vector({114{1'b1}}, 113'd0, {113{1'b1}}, 1'b0, 1'b1, "max_sum");
    test_vector((114'd1 << 113) + 114'd5, 113'd1 << 112, (113'd1 << 112) + 113'd5, 1'b0, 1'b0, "fit_top");
  endtask

  task automatic test_back_to_back();
    logic [114:0] exp_q [$];
    int           got = 0;
    int           extra = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    fork
      begin : drive
        logic [127:0] r;
        logic [113:0] s_v;
        logic [112:0] a_v;
        bit           acc;
        int           tries;
        for (int i = 0; i < 8; i++) begin
          r   = {$urandom(), $urandom(), $urandom(), $urandom()};
          s_v = r[113:0];
          r   = {$urandom(), $urandom(), $urandom(), $urandom()};
          a_v = r[112:0];
          if (i % 2 == 1) s_v = s_v >> 4;
          tries = 0;
          do begin
            sum = s_v; a = a_v; in_valid = 1'b1;
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            tries++;
          end while (!acc && tries < 50);
          exp_q.push_back({1'b0, s_v} - {2'b0, a_v});
        end
        in_valid = 1'b0;
      end
      begin : stall
        repeat (7) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready got %b want 0", in_ready);
          end
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
      begin : monitor
        logic [114:0] d;
        logic [112:0] pb;
        logic         puf, pof;
        bit           prev_stall = 1'b0;
        int           cyc = 0;
        while (got < 8 && cyc < 300) begin
          @(negedge clk); cyc++;
          if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || b !== pb || underflow !== puf || overflow !== pof) begin
              errors++;
              $display("FAIL hold got valid=%b b=%h uf=%b of=%b want valid=1 b=%h uf=%b of=%b",
                       out_valid, b, underflow, overflow, pb, puf, pof);
            end
          end
          if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL b2b_extra got b=%h want no output", b);
            end else begin
              d = exp_q.pop_front();
              if (b !== d[112:0] || underflow !== d[114] || overflow !== (d[113] & ~d[114])) begin
                errors++;
                $display("FAIL b2b_item%0d got b=%h uf=%b of=%b want b=%h uf=%b of=%b", got,
                         b, underflow, overflow, d[112:0], d[114], d[113] & ~d[114]);
              end
            end
            got++;
          end
          prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
          pb = b; puf = underflow; pof = overflow;
        end
      end
    join
    checks++;
    if (got != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got %0d outputs (%0d left) want 8 (0 left)", got, exp_q.size());
    end
    repeat (10) begin
      @(negedge clk);
      if (out_valid === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL b2b_duplicate got %0d extra valid cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      sum = 114'(i + 10); a = 113'(i); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || b !== '0) begin
      errors++;
      $display("FAIL mid_reset got valid=%b b=%h want valid=0 b=0", out_valid, b);
    end
    repeat (10) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_reset_stale got %0d valid cycles want 0", seen);
    end
    test_vector(114'd100, 113'd58, 113'd42, 1'b0, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
